// File: rtl/seq_restoring_divider_pkg.sv
// Shared definitions for the sequential restoring divider: state encodings
// and the default operand / iteration-counter widths.
package seq_restoring_divider_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_CNT_W = 6;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } divState_t;

   // Number of counter bits needed to index WIDTH iterations.
   function automatic int minCountBits(input int width);
      int bits;
      bits = 1;
      while ((1 << bits) <= width) bits++;
      return bits;
   endfunction

endpackage

// File: rtl/seq_restoring_divider_trial_subtractor.sv
// Combinational N-bit ripple subtractor (a - b) built from a chain of full
// subtractors, one per bit. o_borrowOut is the borrow leaving the MSB stage,
// which is high exactly when a < b as unsigned numbers.
module trial_subtractor #(
   parameter int N = 33
) (
   input  logic [N-1:0] i_a,
   input  logic [N-1:0] i_b,
   output logic [N-1:0] o_diff,
   output logic         o_borrowOut
);

   logic [N:0] w_borrow;

   assign w_borrow[0] = 1'b0;

   for (genvar g = 0; g < N; g++) begin : g_stage
      assign o_diff[g]       = i_a[g] ^ i_b[g] ^ w_borrow[g];
      assign w_borrow[g + 1] = (~i_a[g] & i_b[g]) | (~(i_a[g] ^ i_b[g]) & w_borrow[g]);
   end

   assign o_borrowOut = w_borrow[N];

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider. One trial subtraction per clock in
// RUN; the subtractor's borrow decides whether the partial remainder is
// restored (quotient bit 0) or replaced by the difference (quotient bit 1).
// A zero divisor skips the iterations and reports div_by_zero directly.
module seq_restoring_divider
   import seq_restoring_divider_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH - 1);

   divState_t        r_state;
   divState_t        w_nextState;
   logic [CNT_W-1:0] r_count;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_r;
   logic [WIDTH-1:0] r_divisor;
   logic [WIDTH-1:0] r_quotient;
   logic [WIDTH-1:0] r_remainder;
   logic             r_divByZero;

   logic [WIDTH:0]   w_shiftedRem;
   logic [WIDTH:0]   w_trialDiff;
   logic             w_borrow;
   logic             w_restore;
   logic [WIDTH:0]   w_nextRemWide;
   logic [WIDTH-1:0] w_nextRem;
   logic [WIDTH-1:0] w_nextQ;
   logic             w_divisorZero;
   logic             w_lastIter;

   // Shift the next dividend bit into the partial remainder for the trial.
   assign w_shiftedRem  = {r_r, r_q[WIDTH-1]};
   assign w_divisorZero = (divisor == '0);
   assign w_lastIter    = (r_count == LAST_COUNT);

   trial_subtractor #(
      .N (WIDTH + 1)
   ) u_trialSub (
      .i_a         (w_shiftedRem),
      .i_b         ({1'b0, r_divisor}),
      .o_diff      (w_trialDiff),
      .o_borrowOut (w_borrow)
   );

   // A non-borrowing difference is always below the divisor, so its top bit
   // is zero; folding that bit into the select keeps the narrowed remainder
   // exact without a separate truncation path.
   assign w_restore     = w_borrow | w_trialDiff[WIDTH];
   assign w_nextRemWide = w_restore ? w_shiftedRem : w_trialDiff;
   assign w_nextRem     = w_nextRemWide[WIDTH-1:0];
   assign w_nextQ       = {r_q[WIDTH-2:0], ~w_restore};

   // State register; reset always returns the controller to IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state selection and the status outputs decoded from the state.
   always_comb begin
      w_nextState = r_state;
      busy        = 1'b0;
      done        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_nextState = w_divisorZero ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            busy = 1'b1;
            if (w_lastIter) begin
               w_nextState = S_DONE;
            end
         end
         S_DONE: begin
            done        = 1'b1;
            w_nextState = S_IDLE;
         end
         default: begin
            w_nextState = S_IDLE;
         end
      endcase
   end

   // Datapath: operand capture on accept, one iteration per RUN cycle, and
   // result registers that only change when the controller enters DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count     <= '0;
         r_q         <= '0;
         r_r         <= '0;
         r_divisor   <= '0;
         r_quotient  <= '0;
         r_remainder <= '0;
         r_divByZero <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_divByZero <= w_divisorZero;
                  if (w_divisorZero) begin
                     r_quotient  <= '1;
                     r_remainder <= dividend;
                  end else begin
                     r_q       <= dividend;
                     r_r       <= '0;
                     r_divisor <= divisor;
                     r_count   <= '0;
                  end
               end
            end
            S_RUN: begin
               r_q     <= w_nextQ;
               r_r     <= w_nextRem;
               r_count <= r_count + CNT_W'(1);
               if (w_lastIter) begin
                  r_quotient  <= w_nextQ;
                  r_remainder <= w_nextRem;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign quotient    = r_quotient;
   assign remainder   = r_remainder;
   assign div_by_zero = r_divByZero;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider. Expected results come from
// plain integer division in refDivide; latencies are fixed constants.
module tb_seq_restoring_divider;

   localparam int WIDTH   = 32;
   localparam int CNT_W   = 6;
   localparam int TIMEOUT = 200;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   seq_restoring_divider #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   // Reference: ordinary unsigned division, with the zero-divisor convention.
   function automatic void refDivide(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                     output logic [WIDTH-1:0] q, output logic [WIDTH-1:0] r,
                                     output logic dz);
      if (b == '0) begin
         q  = '1;
         r  = a;
         dz = 1'b1;
      end else begin
         q  = a / b;
         r  = a % b;
         dz = 1'b0;
      end
   endfunction

   // Wait for IDLE, present one request for a single edge, scramble the
   // inputs afterwards, and count edges (accepting edge = 1) until done.
   task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                output int edges);
      int guard;
      guard = 0;
      @(negedge clk);
      while ((busy || done) && guard < TIMEOUT) begin
         @(negedge clk);
         guard++;
      end
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      @(posedge clk);
      #1;
      start    = 1'b0;
      dividend = $urandom;
      divisor  = $urandom;
      edges    = 1;
      while (!done && edges < TIMEOUT) begin
         @(posedge clk);
         #1;
         edges++;
      end
   endtask

   task automatic test_reset();
      rst      = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if ({busy, done, div_by_zero} !== 3'b000) begin
         miscompares++;
         $display("[TB] FAIL reset_flags: busy/done/dbz=%b expected 000", {busy, done, div_by_zero});
      end
      vectors++;
      if (quotient !== '0 || remainder !== '0) begin
         miscompares++;
         $display("[TB] FAIL reset_results: q=%h r=%h expected 0/0", quotient, remainder);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_directed();
      logic [WIDTH-1:0] dirA [0:6] = '{32'd1200, 32'd7, 32'd3, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5};
      logic [WIDTH-1:0] dirB [0:6] = '{32'd1100, 32'd2, 32'd10, 32'd1, 32'd1, 32'h8000_0000, 32'd0};
      logic [WIDTH-1:0] expQ, expR;
      logic             expDz;
      int               edges, expEdges;
      for (int i = 0; i < 7; i++) begin
         refDivide(dirA[i], dirB[i], expQ, expR, expDz);
         expEdges = (dirB[i] == '0) ? 1 : WIDTH + 1;
         applyStimulus(dirA[i], dirB[i], edges);
         vectors++;
         if (edges !== expEdges) begin
            miscompares++;
            $display("[TB] FAIL directed_latency[%0d]: %0d edges expected %0d", i, edges, expEdges);
         end
         vectors++;
         if (quotient !== expQ || remainder !== expR || div_by_zero !== expDz) begin
            miscompares++;
            $display("[TB] FAIL directed_result[%0d] %0d/%0d: q=%h r=%h dz=%b expected q=%h r=%h dz=%b",
                     i, dirA[i], dirB[i], quotient, remainder, div_by_zero, expQ, expR, expDz);
         end
         @(posedge clk);
         #1;
         vectors++;
         if (done !== 1'b0 || quotient !== expQ || remainder !== expR) begin
            miscompares++;
            $display("[TB] FAIL directed_pulse_hold[%0d]: done=%b q=%h r=%h expected done=0 q=%h r=%h",
                     i, done, quotient, remainder, expQ, expR);
         end
      end
   endtask

   task automatic test_ignored_start();
      int edges;
      int guard;
      guard = 0;
      @(negedge clk);
      while ((busy || done) && guard < TIMEOUT) begin
         @(negedge clk);
         guard++;
      end
      start    = 1'b1;
      dividend = 32'd1200;
      divisor  = 32'd100;
      @(posedge clk);
      #1;
      start = 1'b0;
      edges = 1;
      repeat (4) begin
         @(posedge clk);
         #1;
         edges++;
      end
      @(negedge clk);
      start    = 1'b1;
      dividend = 32'd9;
      divisor  = 32'd3;
      @(posedge clk);
      #1;
      edges++;
      start = 1'b0;
      while (!done && edges < TIMEOUT) begin
         @(posedge clk);
         #1;
         edges++;
      end
      vectors++;
      if (edges !== WIDTH + 1) begin
         miscompares++;
         $display("[TB] FAIL ignored_start_latency: %0d edges expected %0d", edges, WIDTH + 1);
      end
      vectors++;
      if (quotient !== 32'd12 || remainder !== 32'd0) begin
         miscompares++;
         $display("[TB] FAIL ignored_start_result: q=%0d r=%0d expected q=12 r=0", quotient, remainder);
      end
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         vectors++;
         if (quotient !== 32'd12 || remainder !== 32'd0 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL held_result[%0d]: q=%0d r=%0d busy=%b expected 12/0/0", c, quotient, remainder, busy);
         end
      end
   endtask

   task automatic test_reset_mid_run();
      int doneSeen;
      int edges;
      int guard;
      guard = 0;
      @(negedge clk);
      while ((busy || done) && guard < TIMEOUT) begin
         @(negedge clk);
         guard++;
      end
      start    = 1'b1;
      dividend = 32'd1000;
      divisor  = 32'd3;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL abort_flags: busy=%b done=%b dz=%b expected 0/0/0", busy, done, div_by_zero);
      end
      vectors++;
      if (quotient !== '0 || remainder !== '0) begin
         miscompares++;
         $display("[TB] FAIL abort_results: q=%h r=%h expected 0/0", quotient, remainder);
      end
      @(negedge clk);
      rst      = 1'b0;
      doneSeen = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (done) doneSeen++;
      end
      vectors++;
      if (doneSeen !== 0) begin
         miscompares++;
         $display("[TB] FAIL abort_no_done: saw %0d done cycles expected 0", doneSeen);
      end
      applyStimulus(32'd100, 32'd7, edges);
      vectors++;
      if (quotient !== 32'd14 || remainder !== 32'd2 || edges !== WIDTH + 1) begin
         miscompares++;
         $display("[TB] FAIL after_abort: q=%0d r=%0d edges=%0d expected q=14 r=2 edges=%0d",
                  quotient, remainder, edges, WIDTH + 1);
      end
   endtask

   task automatic test_back_to_back();
      logic [WIDTH-1:0] a0, b0, a1, b1, expQ, expR;
      logic             expDz;
      int               count, firstDone, secondDone, guard;
      a0 = $urandom;
      b0 = $urandom_range(1, 5000);
      a1 = $urandom;
      b1 = ($urandom >> $urandom_range(0, 31)) | 32'd1;
      guard = 0;
      @(negedge clk);
      while ((busy || done) && guard < TIMEOUT) begin
         @(negedge clk);
         guard++;
      end
      start    = 1'b1;
      dividend = a0;
      divisor  = b0;
      count      = 0;
      firstDone  = -1;
      secondDone = -1;
      while (secondDone < 0 && count < 4 * TIMEOUT) begin
         @(posedge clk);
         #1;
         count++;
         if (done) begin
            if (firstDone < 0) begin
               firstDone = count;
               refDivide(a0, b0, expQ, expR, expDz);
               vectors++;
               if (quotient !== expQ || remainder !== expR) begin
                  miscompares++;
                  $display("[TB] FAIL b2b_first %h/%h: q=%h r=%h expected q=%h r=%h",
                           a0, b0, quotient, remainder, expQ, expR);
               end
               dividend = a1;
               divisor  = b1;
            end else begin
               secondDone = count;
               start      = 1'b0;
               refDivide(a1, b1, expQ, expR, expDz);
               vectors++;
               if (quotient !== expQ || remainder !== expR) begin
                  miscompares++;
                  $display("[TB] FAIL b2b_second %h/%h: q=%h r=%h expected q=%h r=%h",
                           a1, b1, quotient, remainder, expQ, expR);
               end
            end
         end
      end
      start = 1'b0;
      vectors++;
      if (secondDone - firstDone !== WIDTH + 2 || firstDone !== WIDTH + 1) begin
         miscompares++;
         $display("[TB] FAIL b2b_period: first done at %0d, second at %0d expected %0d and %0d",
                  firstDone, secondDone, WIDTH + 1, 2 * WIDTH + 3);
      end
   endtask

   task automatic test_random();
      logic [WIDTH-1:0] a, b, expQ, expR;
      logic             expDz;
      int               edges, expEdges;
      for (int i = 0; i < 24; i++) begin
         a = $urandom;
         case ($urandom_range(0, 4))
            0:       b = $urandom;
            1:       b = $urandom_range(1, 15);
            2:       b = $urandom >> $urandom_range(0, 31);
            3:       begin a = $urandom_range(0, 1000); b = $urandom_range(1, 2000); end
            default: b = (i % 8 == 0) ? '0 : a;
         endcase
         refDivide(a, b, expQ, expR, expDz);
         expEdges = (b == '0) ? 1 : WIDTH + 1;
         applyStimulus(a, b, edges);
         vectors++;
         if (quotient !== expQ || remainder !== expR || div_by_zero !== expDz || edges !== expEdges) begin
            miscompares++;
            $display("[TB] FAIL random[%0d] %h/%h: q=%h r=%h dz=%b edges=%0d expected q=%h r=%h dz=%b edges=%0d",
                     i, a, b, quotient, remainder, div_by_zero, edges, expQ, expR, expDz, expEdges);
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_ignored_start();
      test_reset_mid_run();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
